// File: rtl/pwm_fade_ctrl_pkg.sv
// pwm_fade_ctrl_pkg: command codes, FSM state encodings and field widths shared by the fade controller
package pwm_fade_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_SET     = 2'b00,
        MODE_RAMP    = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_STOP    = 2'b11
    } mode_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_BUP  = 2'd2;
    localparam logic [1:0] ST_BDN  = 2'd3;

    localparam int CMD_STEP_W = 4;
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: free-running step-enable divider; clr restarts the period so a step lands TICK_DIV cycles later
module pwm_tick_gen #(
    parameter int TICK_DIV = 500_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(TICK_DIV - 1);

    always_ff @(posedge sys_clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: SET/RAMP/BREATHE/STOP brightness sequencer driving a shared PWM din port
module pwm_fade_ctrl
    import pwm_fade_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 500_000,
    parameter int LVL_W    = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [LVL_W-1:0]      cmd_level,
    input  logic [CMD_STEP_W-1:0] cmd_step,
    output logic [LVL_W-1:0]      din,
    output logic                  busy,
    output logic                  done
);
    logic [1:0]            state;
    logic [LVL_W-1:0]      target, up_nxt, dn_floor, ramp_nxt;
    logic [CMD_STEP_W-1:0] step, step_eff;
    logic [LVL_W:0]        up, dn;
    logic                  accept, tick;

    assign cmd_ready = state != ST_RAMP;
    assign busy      = state != ST_IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign step_eff  = (cmd_step == '0) ? CMD_STEP_W'(1) : cmd_step;

    pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .sys_clk(sys_clk),
        .rst    (rst),
        .clr    (accept),
        .tick   (tick)
    );

    // One extra bit on the sum/difference exposes overflow and underflow for clamping
    always_comb begin
        up       = {1'b0, din} + (LVL_W + 1)'(step);
        dn       = {1'b0, din} - (LVL_W + 1)'(step);
        up_nxt   = (up > {1'b0, target}) ? target : up[LVL_W-1:0];
        dn_floor = dn[LVL_W] ? '0 : dn[LVL_W-1:0];
        ramp_nxt = (din < target) ? up_nxt
                 : ((dn[LVL_W] || dn[LVL_W-1:0] < target) ? target : dn[LVL_W-1:0]);
    end

    always_ff @(posedge sys_clk or posedge rst)
        if (rst) begin
            state  <= ST_IDLE;
            din    <= '0;
            target <= '0;
            step   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (cmd_mode)
                    MODE_SET: begin
                        din   <= cmd_level;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    MODE_RAMP: begin
                        target <= cmd_level;
                        step   <= step_eff;
                        done   <= din == cmd_level;
                        state  <= (din == cmd_level) ? ST_IDLE : ST_RAMP;
                    end
                    MODE_BREATHE: begin
                        target <= cmd_level;
                        step   <= step_eff;
                        state  <= ST_BUP;
                    end
                    default: begin
                        din   <= '0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tick) begin
                case (state)
                    ST_RAMP: begin
                        din   <= ramp_nxt;
                        done  <= ramp_nxt == target;
                        state <= (ramp_nxt == target) ? ST_IDLE : ST_RAMP;
                    end
                    // A turn-around tick only changes direction; din holds for that tick
                    ST_BUP: if (din == target) state <= ST_BDN; else din <= up_nxt;
                    ST_BDN: if (din == '0) state <= ST_BUP; else din <= dn_floor;
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: scoreboarded check of pwm_fade_ctrl with TICK_DIV=4
module tb_pwm_fade_ctrl;
    import pwm_fade_ctrl_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] din;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [7:0] cmd_level = 8'd0;
    logic [3:0] cmd_step = 4'd0;
    logic [7:0] din;
    logic       busy;
    logic       done;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_din = 8'd0;
    logic       exp_done;
    exp_t       sb[$];
    exp_t       e;

    pwm_fade_ctrl #(.TICK_DIV(4), .LVL_W(8)) dut (
        .sys_clk  (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_level(cmd_level),
        .cmd_step (cmd_step),
        .din      (din),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every cycle din must hold the latest expected level, done only where expected
    always @(negedge clk) if (mon_en) begin
        exp_done = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            exp_din  = e.din;
            exp_done = e.done;
        end
        total++;
        if (din !== exp_din || done !== exp_done) begin
            bad++;
            $display("FAIL sb cyc=%0d din=%0d done=%b required din=%0d done=%b", cyc, din, done, exp_din, exp_done);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic expect_at(input int c, input int v, input bit d);
        sb.push_back('{c, 8'(v), d});
    endtask

    task automatic send(input logic [1:0] m, input int l, input int s, output int a);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_level = 8'(l);
        cmd_step  = 4'(s);
        @(posedge clk);
        #1;
        a = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (din !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset k=%0d din=%0d ready=%b busy=%b done=%b required 0/1/0/0", k, din, cmd_ready, busy, done);
            end
        end
        exp_din = 8'd0;
        mon_en  = 1'b1;
    endtask

    task automatic test_set;
        int a;
        send(MODE_SET, 200, 0, a);
        expect_at(a, 200, 1);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL set_flags busy=%b ready=%b required 0/1", busy, cmd_ready);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ramp;
        int a;
        send(MODE_SET, 10, 0, a);
        expect_at(a, 10, 1);
        repeat (2) @(negedge clk);
        send(MODE_RAMP, 20, 4, a);
        expect_at(a + 4, 14, 0);
        expect_at(a + 8, 18, 0);
        expect_at(a + 12, 20, 1);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            total++;
            if (cmd_ready !== (k >= 12) || busy !== (k < 12)) begin
                bad++;
                $display("FAIL ramp_flags k=%0d ready=%b busy=%b required %b/%b", k, cmd_ready, busy, k >= 12, k < 12);
            end
            // A competing SET held against the non-interruptible ramp must be ignored
            if (k == 2) begin
                cmd_valid = 1'b1;
                cmd_mode  = MODE_SET;
                cmd_level = 8'd99;
            end
            if (k == 11) cmd_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_breathe;
        int a, b;
        int bv[12] = '{3, 6, 9, 10, 10, 7, 4, 1, 0, 0, 3, 6};
        send(MODE_STOP, 0, 0, a);
        expect_at(a, 0, 1);
        repeat (2) @(negedge clk);
        send(MODE_BREATHE, 10, 3, a);
        for (int k = 0; k < 12; k++) expect_at(a + 4 * (k + 1), bv[k], 0);
        wait_cyc(a + 49);
        total++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL breathe_flags busy=%b ready=%b required 1/1", busy, cmd_ready);
        end
        send(MODE_SET, 5, 0, b);
        expect_at(b, 5, 1);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL breathe_interrupt busy=%b required 0", busy);
        end
    endtask

    task automatic test_ramp_down_clamp;
        int a, v, k;
        send(MODE_SET, 255, 0, a);
        expect_at(a, 255, 1);
        repeat (2) @(negedge clk);
        send(MODE_RAMP, 40, 15, a);
        v = 255;
        k = 0;
        while (v != 40) begin
            k++;
            v = (v - 15 < 40) ? 40 : v - 15;
            expect_at(a + 4 * k, v, v == 40);
        end
        wait_cyc(a + 4 * k + 3);
    endtask

    task automatic test_ramp_equal;
        int a;
        send(MODE_RAMP, 40, 5, a);
        expect_at(a, 40, 1);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ramp_equal busy=%b ready=%b required 0/1", busy, cmd_ready);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_breathe_above_peak;
        int a, b;
        send(MODE_BREATHE, 10, 2, a);
        expect_at(a + 4, 10, 0);
        expect_at(a + 12, 8, 0);
        expect_at(a + 16, 6, 0);
        wait_cyc(a + 17);
        send(MODE_STOP, 0, 0, b);
        expect_at(b, 0, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_no_wrap;
        int a;
        send(MODE_SET, 250, 0, a);
        expect_at(a, 250, 1);
        repeat (2) @(negedge clk);
        send(MODE_RAMP, 255, 0, a);
        for (int k = 1; k <= 5; k++) expect_at(a + 4 * k, 250 + k, k == 5);
        wait_cyc(a + 32);
    endtask

    task automatic test_reset_mid_ramp;
        int a;
        send(MODE_STOP, 0, 0, a);
        expect_at(a, 0, 1);
        repeat (2) @(negedge clk);
        send(MODE_RAMP, 255, 0, a);
        for (int k = 1; k <= 100; k++) expect_at(a + 4 * k, k, 0);
        wait_cyc(a + 401);
        mon_en = 1'b0;
        total++;
        if (din !== 8'd100 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset din=%0d ready=%b required 100/0", din, cmd_ready);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (din !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset din=%0d ready=%b busy=%b done=%b required 0/1/0/0", din, cmd_ready, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_din = 8'd0;
        mon_en  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_set();
        test_ramp();
        test_breathe();
        test_ramp_down_clamp();
        test_ramp_equal();
        test_breathe_above_peak();
        test_no_wrap();
        test_reset_mid_ramp();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
